// File: rtl/panel_io_pkg.sv
// Shared definitions for the front-panel I/O block: LED mode encoding
// and a small elaboration-time helper.
package panel_io_pkg;

  typedef enum logic [1:0] {
    LED_STATIC = 2'd0,
    LED_BLINK  = 2'd1,
    LED_PWM    = 2'd2,
    LED_MIRROR = 2'd3
  } led_mode_t;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/panel_io_ctrl_btn_debounce.sv
// One push-button channel: inversion, two-flop synchroniser, debounce
// counter, accepted level and a single-cycle pulse on each accepted press.
module btn_debounce import panel_io_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 48000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sample;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          level_q;
  logic          press_q;

  assign sample = sync_q[1];

  // A change is accepted only after DEBOUNCE_CYCLES consecutive differing
  // samples; any sample that agrees with the stable value restarts the run.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sample != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sample;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], ~button_n_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      level_q  <= stable_q;
      press_q  <= stable_q & ~level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/panel_io_ctrl.sv
// Front-panel I/O: debounced buttons with press counters, and active-low
// LEDs driven in static, blink, PWM-dim or button-mirror mode.
module panel_io_ctrl import panel_io_pkg::*; #(
  parameter int N_BTN           = 4,
  parameter int N_LED           = 8,
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int BLINK_LOG2      = 23,
  parameter int CNT_W           = 8
) (
  input  logic                   ti_clk,
  input  logic                   reset,
  input  logic [N_BTN-1:0]       button,
  output logic [N_LED-1:0]       led,
  input  logic [N_LED-1:0]       led_value,
  input  logic [1:0]             led_mode,
  input  logic [7:0]             led_duty,
  input  logic                   clear_counts,
  output logic [N_BTN-1:0]       btn_level,
  output logic [N_BTN-1:0]       btn_press,
  output logic [N_BTN*CNT_W-1:0] btn_count
);

  localparam int N_MIRROR = min_int(N_LED, N_BTN);

  logic [N_BTN-1:0][CNT_W-1:0] count_q, count_d;
  logic [BLINK_LOG2-1:0]       presc_q;
  logic                        phase_q;
  logic [7:0]                  pwm_q;
  logic [N_LED-1:0]            on;
  logic [N_LED-1:0]            led_q, led_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i     (ti_clk),
      .reset_i   (reset),
      .button_n_i(button[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i])
    );
  end

  // Clearing wins over a simultaneous press so the host sees a clean zero.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (clear_counts) begin
        count_d[i] = '0;
      end else if (btn_press[i]) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    on = led_value;
    case (led_mode_t'(led_mode))
      LED_STATIC: on = led_value;
      LED_BLINK:  on = led_value & {N_LED{phase_q}};
      LED_PWM:    on = (pwm_q < led_duty) ? led_value : '0;
      LED_MIRROR: begin
        on = led_value;
        for (int i = 0; i < N_MIRROR; i++) begin
          on[i] = btn_level[i];
        end
      end
      default:    on = led_value;
    endcase
    led_d = ~on;
  end

  // Prescaler and PWM counter free-run regardless of mode.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      count_q <= '0;
      presc_q <= '0;
      phase_q <= 1'b0;
      pwm_q   <= '0;
      led_q   <= '1;
    end else begin
      count_q <= count_d;
      presc_q <= presc_q + BLINK_LOG2'(1);
      if (presc_q == '1) begin
        phase_q <= ~phase_q;
      end
      pwm_q   <= pwm_q + 8'd1;
      led_q   <= led_d;
    end
  end

  assign led       = led_q;
  assign btn_count = count_q;

endmodule
